// File: rtl/lfsr_pkg.sv
// Shared definitions for the 21-bit Fibonacci LFSR (x^21 + x^18 + 1) used by
// both the random byte generator and the stream checker, so the polynomial is
// defined in exactly one place.
package lfsr_pkg;

    localparam int LFSR_LEN = 21;
    localparam int TAP_HI   = 20;
    localparam int TAP_LO   = 17;

    // Checker states: SEED fills the local register from the stream,
    // CHECK predicts every byte from the local register (flywheel).
    typedef enum logic {
        ST_SEED  = 1'b0,
        ST_CHECK = 1'b1
    } chk_state_t;

    // One LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [LFSR_LEN-1:0] lfsr_next(input logic [LFSR_LEN-1:0] r);
        return {r[LFSR_LEN-2:0], r[TAP_HI] ^ r[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr_err_counter.sv
// Saturating mismatch counter. A clear in the same cycle as an increment wins,
// so software sees a clean zero after clearing.
module lfsr_err_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Next count: clear has priority, otherwise increment until all-ones.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 21-bit Fibonacci LFSR byte stream. Seeds a
// local LFSR from bit 0 of 21 incoming bytes, then predicts every following
// byte and counts mismatches. Too many mismatches inside one evaluation window
// drops lock and reseeds from the stream.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int ERR_W  = $clog2(WINDOW + 1);
    localparam int SEED_W = $clog2(LFSR_LEN);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0]  ERR_LIMIT = ERR_W'(LOSS_THRESH);
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(LFSR_LEN - 1);

    chk_state_t          state_reg,    state_next;
    logic [LFSR_LEN-1:0] shreg_reg,    shreg_next;
    logic [SEED_W-1:0]   seed_cnt_reg, seed_cnt_next;
    logic [WIN_W-1:0]    win_cnt_reg,  win_cnt_next;
    logic [ERR_W-1:0]    win_err_reg,  win_err_next;
    logic                err_pulse_reg;

    logic [LFSR_LEN-1:0] seed_shift;   // shreg with the received bit appended
    logic [LFSR_LEN-1:0] predicted;    // shreg advanced by the local polynomial
    logic [7:0]          expected;
    logic                mismatch;
    logic [ERR_W-1:0]    win_err_sum;

    assign seed_shift  = {shreg_reg[LFSR_LEN-2:0], in_data[0]};
    assign predicted   = lfsr_next(shreg_reg);
    assign expected    = predicted[7:0];
    assign mismatch    = (state_reg == ST_CHECK) && in_valid && (in_data != expected);
    assign win_err_sum = win_err_reg + ERR_W'(mismatch);

    // Next-state logic: seeding, prediction flywheel and loss-of-lock window.
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        seed_cnt_next = seed_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_err_next  = win_err_reg;

        unique case (state_reg)
            ST_SEED: begin
                if (in_valid) begin
                    shreg_next = seed_shift;
                    if (seed_cnt_reg == SEED_LAST) begin
                        seed_cnt_next = '0;
                        // An all-zero register would predict zeros forever, so
                        // that pattern restarts seeding instead of locking.
                        if (seed_shift != '0) begin
                            state_next   = ST_CHECK;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end else begin
                        seed_cnt_next = seed_cnt_reg + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (in_valid) begin
                    // Advance on the prediction only, so a corrupted byte
                    // never propagates into the local register.
                    shreg_next = predicted;
                    if (win_err_sum >= ERR_LIMIT) begin
                        state_next    = ST_SEED;
                        seed_cnt_next = '0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else if (win_cnt_reg == WIN_LAST) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + 1'b1;
                        win_err_next = win_err_sum;
                    end
                end
            end
            default: begin
                state_next = ST_SEED;
            end
        endcase
    end

    // State, shift register, counters and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_SEED;
            shreg_reg     <= '0;
            seed_cnt_reg  <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            seed_cnt_reg  <= seed_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            err_pulse_reg <= mismatch;
        end
    end

    lfsr_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch),
        .clear (clear),
        .count (err_count)
    );

    assign locked    = (state_reg == ST_CHECK);
    assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: table-driven single-error sequence, hand-written
// lock/loss/saturation sequences and a randomized run against a reference model.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    // Second instance: small counter, loss only at the end of a full window.
    logic        rst6_n;
    logic        in_valid6;
    logic [7:0]  in_data6;
    logic        clear6;
    logic        locked6;
    logic        err_pulse6;
    logic [3:0]  err_count6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_stream_checker #(.WINDOW(64), .LOSS_THRESH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    lfsr_stream_checker #(.WINDOW(16), .LOSS_THRESH(16), .CNT_W(4)) dut6 (
        .clk(clk), .rst_n(rst6_n), .in_valid(in_valid6), .in_data(in_data6),
        .clear(clear6), .locked(locked6), .err_pulse(err_pulse6), .err_count(err_count6)
    );

    // ---------------- stream generators (independent of the DUT) ----------
    int unsigned gen  = 32'h1F_FFFF;   // seeded all-ones
    int unsigned gen6 = 32'h1F_FFFF;

    function automatic int unsigned lfsr_step(input int unsigned r);
        int unsigned fb;
        fb = ((r >> 20) ^ (r >> 17)) & 1;
        return ((r << 1) | fb) & 32'h1F_FFFF;
    endfunction

    // ---------------- reference model ------------------------------------
    // Keeps the last 21 received bits while seeding; while locked, keeps the
    // predicted generator state and compares whole bytes.
    bit          m_locked;
    int unsigned m_reg;
    int          m_seed_n;
    int          m_win_n;
    int          m_win_err;
    bit          m_pulse;
    int          m_count;

    function automatic void model_reset();
        m_locked = 0; m_reg = 0; m_seed_n = 0;
        m_win_n = 0; m_win_err = 0; m_pulse = 0; m_count = 0;
    endfunction

    function automatic void model_update(input bit v, input logic [7:0] d, input bit c);
        bit mis = 0;
        if (v) begin
            if (!m_locked) begin
                m_reg = ((m_reg << 1) | d[0]) & 32'h1F_FFFF;
                m_seed_n++;
                if (m_seed_n == 21) begin
                    m_seed_n = 0;
                    if (m_reg != 0) begin
                        m_locked = 1; m_win_n = 0; m_win_err = 0;
                    end
                end
            end else begin
                m_reg = lfsr_step(m_reg);
                mis = (d != m_reg[7:0]);
                m_win_n++;
                if (mis) m_win_err++;
                if (m_win_err >= 8) begin
                    m_locked = 0; m_seed_n = 0; m_win_n = 0; m_win_err = 0;
                end else if (m_win_n == 64) begin
                    m_win_n = 0; m_win_err = 0;
                end
            end
        end
        m_pulse = mis;
        if (c) m_count = 0;
        else if (mis && m_count < 65535) m_count++;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle on the main DUT, advance the model, compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit c);
        in_valid = v; in_data = d; clear = c;
        @(posedge clk);
        model_update(v, d, c);
        #1;
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
        check("err_count", {16'd0, err_count}, m_count);
    endtask

    // Generator-driven cycle: byte = generator byte xor mask; generator
    // advances only when the byte is consumed.
    task automatic gstep(input bit v, input logic [7:0] mask, input bit c);
        logic [7:0] d;
        d = gen[7:0] ^ mask;
        step(v, d, c);
        if (v) gen = lfsr_step(gen);
    endtask

    task automatic step6(input bit v, input logic [7:0] mask, input bit c);
        in_valid6 = v; in_data6 = gen6[7:0] ^ mask; clear6 = c;
        @(posedge clk);
        #1;
        if (v) gen6 = lfsr_step(gen6);
    endtask

    // Asynchronous reset pulse on the main DUT; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_count", {16'd0, err_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         v;
        logic [7:0] mask;
        bit         c;
        bit         e_locked;
        bit         e_pulse;
        int         e_count;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit any_lock;
        int burst;

        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1};  // single bit-3 flip
        tbl[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1};  // flywheel intact
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 0};  // clear wins, pulse kept
        tbl[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0};  // clear while idle
        tbl[9] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0};

        rst_n = 1'b0; in_valid = 0; in_data = 0; clear = 0;
        rst6_n = 1'b0; in_valid6 = 0; in_data6 = 0; clear6 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_pulse", {31'd0, err_pulse}, 32'd0);
        check("reset_count", {16'd0, err_count}, 32'd0);
        rst_n = 1'b1; rst6_n = 1'b1;

        // 1: clean stream, lock on the cycle after the 21st sample
        for (int i = 0; i < 20; i++) gstep(1, 8'h00, 0);
        check("t1_not_locked_20", {31'd0, locked}, 32'd0);
        gstep(1, 8'h00, 0);
        check("t1_locked_21", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 1000; i++) gstep(1, 8'h00, 0);
        check("t1_count", {16'd0, err_count}, 32'd0);

        // 2: table-driven single-error and clear sequence
        for (int i = 0; i < 10; i++) begin
            gstep(tbl[i].v, tbl[i].mask, tbl[i].c);
            check($sformatf("t2_locked[%0d]", i), {31'd0, locked}, {31'd0, tbl[i].e_locked});
            check($sformatf("t2_pulse[%0d]", i), {31'd0, err_pulse}, {31'd0, tbl[i].e_pulse});
            check($sformatf("t2_count[%0d]", i), {16'd0, err_count}, tbl[i].e_count);
        end

        // 3: eight consecutive errors in a fresh window drop lock, then relock
        do_reset();
        for (int i = 0; i < 21; i++) gstep(1, 8'h00, 0);
        check("t3_locked", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 7; i++) gstep(1, 8'hFF, 0);
        check("t3_still_locked_7", {31'd0, locked}, 32'd1);
        gstep(1, 8'hFF, 0);
        check("t3_unlock_8", {31'd0, locked}, 32'd0);
        check("t3_count_8", {16'd0, err_count}, 32'd8);
        for (int i = 0; i < 20; i++) gstep(1, 8'h00, 0);
        check("t3_not_relocked_20", {31'd0, locked}, 32'd0);
        gstep(1, 8'h00, 0);
        check("t3_relocked_21", {31'd0, locked}, 32'd1);

        // 4: in_valid toggled pseudo-randomly on a clean stream
        do_reset();
        for (int i = 0; i < 200; i++) gstep(1'($urandom_range(0, 1)), 8'h00, 0);
        check("t4_locked", {31'd0, locked}, 32'd1);
        check("t4_count", {16'd0, err_count}, 32'd0);

        // 5: all-zero stream never locks
        do_reset();
        any_lock = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 8'h00, 0);
            if (locked) any_lock = 1;
        end
        check("t5_never_locked", {31'd0, any_lock}, 32'd0);
        check("t5_count", {16'd0, err_count}, 32'd0);

        // Randomized run: valid gaps, error bursts, clears, occasional reset
        do_reset();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            bit v;
            bit c;
            logic [7:0] mask;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(1, 12);
            mask = 8'h00;
            if (burst > 0 && v) begin
                mask = 8'($urandom_range(1, 255));
                burst--;
            end
            if ($urandom_range(0, 1499) == 0) do_reset();
            gstep(v, mask, c);
        end

        // 6: 4-bit counter saturation, clear vs error, async reset mid-CHECK
        for (int i = 0; i < 21; i++) step6(1, 8'h00, 0);
        check("t6_locked", {31'd0, locked6}, 32'd1);
        for (int i = 0; i < 15; i++) step6(1, 8'h5A, 0);
        check("t6_count_15", {28'd0, err_count6}, 32'd15);
        check("t6_locked_15", {31'd0, locked6}, 32'd1);
        step6(1, 8'h00, 0);   // window wrap with 15 errors: stays locked
        check("t6_wrap_locked", {31'd0, locked6}, 32'd1);
        check("t6_wrap_pulse", {31'd0, err_pulse6}, 32'd0);
        step6(1, 8'h5A, 0);
        check("t6_saturated", {28'd0, err_count6}, 32'd15);
        check("t6_sat_pulse", {31'd0, err_pulse6}, 32'd1);
        step6(1, 8'h5A, 1);
        check("t6_clear_wins", {28'd0, err_count6}, 32'd0);
        check("t6_clear_pulse", {31'd0, err_pulse6}, 32'd1);
        step6(1, 8'h5A, 0);
        check("t6_count_after_clear", {28'd0, err_count6}, 32'd1);
        check("t6_locked_before_rst", {31'd0, locked6}, 32'd1);
        rst6_n = 1'b0;
        #2;
        check("t6_rst_locked", {31'd0, locked6}, 32'd0);
        check("t6_rst_pulse", {31'd0, err_pulse6}, 32'd0);
        check("t6_rst_count", {28'd0, err_count6}, 32'd0);
        @(posedge clk);
        #1;
        rst6_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
